// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared widths, derived burst geometry and FSM encoding for the fetch stage
package inst_fetch_pkg;
    localparam int INST_LEN     = 220;
    localparam int DDR_ADDR_LEN = 32;
    localparam int DDR_DATA_LEN = 64;
    localparam int SINGLE_LEN   = 24;
    localparam int DEPTH_LOG    = 4;
    localparam int BEATS        = (INST_LEN + DDR_DATA_LEN - 1) / DDR_DATA_LEN;
    localparam int INST_BYTES   = BEATS * DDR_DATA_LEN / 8;
    localparam int ASM_LEN      = BEATS * DDR_DATA_LEN;
    localparam int BEAT_W       = BEATS > 1 ? $clog2(BEATS) : 1;
    typedef enum logic [1:0] {IDLE, REQ, RECV} state_t;
endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: configuration, DDR read and instruction-queue signals of the fetch stage
interface inst_fetch_if;
    import inst_fetch_pkg::*;
    logic                    ifc_conf;
    logic [DDR_ADDR_LEN-1:0] ifc_ddr_st_addr;
    logic [SINGLE_LEN-1:0]   ifc_inst_num;
    logic                    ifc_idle;
    logic                    rd_req;
    logic [DDR_ADDR_LEN-1:0] rd_addr;
    logic [7:0]              rd_beats;
    logic                    rd_ack;
    logic                    rd_valid;
    logic [DDR_DATA_LEN-1:0] rd_data;
    logic [INST_LEN-1:0]     instruct;
    logic                    inst_empty;
    logic                    inst_req;
    modport master (
        input  ifc_conf, ifc_ddr_st_addr, ifc_inst_num, rd_ack, rd_valid, rd_data, inst_req,
        output ifc_idle, rd_req, rd_addr, rd_beats, instruct, inst_empty
    );
    modport slave (
        output ifc_conf, ifc_ddr_st_addr, ifc_inst_num, rd_ack, rd_valid, rd_data, inst_req,
        input  ifc_idle, rd_req, rd_addr, rd_beats, instruct, inst_empty
    );
endinterface

// File: rtl/inst_fwft_fifo.sv
// inst_fwft_fifo: circular first-word-fall-through buffer; head is zero while empty
module inst_fwft_fifo #(
    parameter int WIDTH     = 220,
    parameter int DEPTH_LOG = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 pop,
    output logic [WIDTH-1:0]     rdata,
    output logic                 empty,
    output logic                 full,
    output logic [DEPTH_LOG:0]   count
);
    logic [WIDTH-1:0]     mem [2**DEPTH_LOG];
    logic [DEPTH_LOG-1:0] wr_ptr, rd_ptr;
    logic                 do_push, do_pop;

    always_comb begin
        empty   = count == '0;
        full    = count[DEPTH_LOG];
        do_push = push && !full;
        do_pop  = pop && !empty;
        rdata   = empty ? '0 : mem[rd_ptr];
    end

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + DEPTH_LOG'(do_push);
            rd_ptr <= rd_ptr + DEPTH_LOG'(do_pop);
            count  <= count + (DEPTH_LOG+1)'(do_push) - (DEPTH_LOG+1)'(do_pop);
        end
    end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: fetches a block of instructions from DDR, one burst each, into a FWFT queue
module inst_fetch
    import inst_fetch_pkg::*;
(
    input logic        clk,
    input logic        rst_n,
    inst_fetch_if.master bus
);
    state_t                  state;
    logic [DDR_ADDR_LEN-1:0] addr;
    logic [SINGLE_LEN-1:0]   rem;
    logic [BEAT_W-1:0]       beat;
    logic [ASM_LEN-1:0]      asm_q, asm_next;
    logic                    req_q, last_beat, push, room_after_push;
    logic                    fifo_full, fifo_empty;
    logic [DEPTH_LOG:0]      fifo_cnt;

    // room_after_push: the queue still has a free slot once the current push lands
    always_comb begin
        asm_next = asm_q;
        asm_next[int'(beat) * DDR_DATA_LEN +: DDR_DATA_LEN] = bus.rd_data;
        last_beat = beat == BEAT_W'(BEATS - 1);
        push = state == RECV && bus.rd_valid && last_beat;
        room_after_push = fifo_cnt < (DEPTH_LOG+1)'(2**DEPTH_LOG - 1) || (bus.inst_req && !fifo_empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            addr  <= '0;
            rem   <= '0;
            beat  <= '0;
            asm_q <= '0;
            req_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.ifc_conf && bus.ifc_inst_num != '0) begin
                    state <= REQ;
                    addr  <= bus.ifc_ddr_st_addr;
                    rem   <= bus.ifc_inst_num;
                    req_q <= !fifo_full;
                end
                REQ: if (req_q && bus.rd_ack) begin
                    state <= RECV;
                    req_q <= 1'b0;
                    beat  <= '0;
                end else begin
                    req_q <= req_q || !fifo_full;
                end
                RECV: if (bus.rd_valid) begin
                    asm_q <= asm_next;
                    beat  <= beat + 1'b1;
                    if (last_beat) begin
                        addr  <= addr + DDR_ADDR_LEN'(INST_BYTES);
                        rem   <= rem - 1'b1;
                        state <= rem == SINGLE_LEN'(1) ? IDLE : REQ;
                        req_q <= rem != SINGLE_LEN'(1) && room_after_push;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ifc_idle   = state == IDLE;
    assign bus.rd_req     = req_q;
    assign bus.rd_addr    = addr;
    assign bus.rd_beats   = 8'(BEATS);
    assign bus.inst_empty = fifo_empty;

    inst_fwft_fifo #(.WIDTH(INST_LEN), .DEPTH_LOG(DEPTH_LOG)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (asm_next[INST_LEN-1:0]),
        .pop   (bus.inst_req),
        .rdata (bus.instruct),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_cnt)
    );
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed stimulus with a queue-based scoreboard for burst addresses and popped instructions
module tb_inst_fetch;
    import inst_fetch_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [31:0]         exp_addr [$];
    logic [INST_LEN-1:0] exp_inst [$];
    logic [31:0]         mon_a;
    logic [INST_LEN-1:0] mon_i;

    inst_fetch_if bus();
    inst_fetch dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [63:0] beat_of(input logic [31:0] a, input int k);
        return {a + 32'(k), ~a ^ (32'h0101_0101 * 32'(k + 1))};
    endfunction

    function automatic logic [INST_LEN-1:0] word_of(input logic [31:0] a);
        logic [255:0] w;
        w = {beat_of(a, 3), beat_of(a, 2), beat_of(a, 1), beat_of(a, 0)};
        return w[INST_LEN-1:0];
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset();
        check("rst_rd_req", 256'(bus.rd_req), 256'(0));
        check("rst_rd_addr", 256'(bus.rd_addr), 256'(0));
        check("rst_idle", 256'(bus.ifc_idle), 256'(1));
        check("rst_empty", 256'(bus.inst_empty), 256'(1));
        check("rst_instruct", 256'(bus.instruct), 256'(0));
        check("rst_beats", 256'(bus.rd_beats), 256'(4));
    endtask

    task automatic expect_fetch(input logic [31:0] a, input int n, input bit insts);
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(a + 32'(i * 32));
            if (insts) exp_inst.push_back(word_of(a + 32'(i * 32)));
        end
    endtask

    task automatic conf(input logic [31:0] a, input int n);
        bus.ifc_conf = 1'b1;
        bus.ifc_ddr_st_addr = a;
        bus.ifc_inst_num = 24'(n);
        tick();
        bus.ifc_conf = 1'b0;
    endtask

    task automatic pop();
        bus.inst_req = 1'b1;
        tick();
        bus.inst_req = 1'b0;
    endtask

    // memory responder: ack two cycles after the request, then four back-to-back beats
    task automatic serve(input bit pop_last = 1'b0, input int abort_k = -1);
        logic [31:0] a;
        int n = 0;
        while (!bus.rd_req && n < 100) begin
            tick();
            n++;
        end
        if (!bus.rd_req) begin
            check("rd_req_timeout", 256'(0), 256'(1));
            return;
        end
        a = bus.rd_addr;
        tick();
        tick();
        check("rd_req_hold", 256'({bus.rd_req, bus.rd_addr}), 256'({1'b1, a}));
        bus.rd_ack = 1'b1;
        tick();
        bus.rd_ack = 1'b0;
        for (int k = 0; k < BEATS; k++) begin
            bus.rd_valid = 1'b1;
            bus.rd_data = beat_of(a, k);
            if (k == abort_k) begin
                #2 rst_n = 1'b0;
                #1 check_reset();
                tick();
                bus.rd_valid = 1'b0;
                rst_n = 1'b1;
                return;
            end
            bus.inst_req = pop_last && k == BEATS - 1;
            tick();
        end
        bus.rd_valid = 1'b0;
        bus.inst_req = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.rd_req && bus.rd_ack) begin
            checks++;
            if (exp_addr.size() == 0) begin
                errors++;
                $display("FAIL burst_addr: got %h, expected no burst", bus.rd_addr);
            end else begin
                mon_a = exp_addr.pop_front();
                if (bus.rd_addr !== mon_a) begin
                    errors++;
                    $display("FAIL burst_addr: got %h, expected %h", bus.rd_addr, mon_a);
                end
            end
        end
        if (rst_n && bus.inst_req && !bus.inst_empty) begin
            checks++;
            if (exp_inst.size() == 0) begin
                errors++;
                $display("FAIL instruct: got %h, expected no instruction", bus.instruct);
            end else begin
                mon_i = exp_inst.pop_front();
                if (bus.instruct !== mon_i) begin
                    errors++;
                    $display("FAIL instruct: got %h, expected %h", bus.instruct, mon_i);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.ifc_conf = 1'b0;
        bus.ifc_ddr_st_addr = '0;
        bus.ifc_inst_num = '0;
        bus.rd_ack = 1'b0;
        bus.rd_valid = 1'b0;
        bus.rd_data = '0;
        bus.inst_req = 1'b0;
        tick();
        check_reset();
        tick();
        rst_n = 1'b1;

        expect_fetch(32'h1000, 3, 1'b1);
        conf(32'h1000, 3);
        check("req_after_conf", 256'(bus.rd_req), 256'(1));
        check("busy_after_conf", 256'(bus.ifc_idle), 256'(0));
        repeat (3) serve();
        check("idle_after_three", 256'(bus.ifc_idle), 256'(1));
        check("nonempty_after_three", 256'(bus.inst_empty), 256'(0));
        check("head_first", 256'(bus.instruct), 256'(word_of(32'h1000)));
        repeat (3) pop();
        check("empty_after_pops", 256'(bus.inst_empty), 256'(1));

        pop();
        check("pop_while_empty", 256'(bus.inst_empty), 256'(1));
        check("instruct_while_empty", 256'(bus.instruct), 256'(0));
        conf(32'h3000, 0);
        check("num_zero_idle", 256'(bus.ifc_idle), 256'(1));
        tick();
        check("num_zero_no_req", 256'(bus.rd_req), 256'(0));
        bus.rd_valid = 1'b1;
        bus.rd_data = '1;
        repeat (4) tick();
        bus.rd_valid = 1'b0;
        check("stray_valid_empty", 256'(bus.inst_empty), 256'(1));
        expect_fetch(32'h2000, 1, 1'b1);
        conf(32'h2000, 1);
        conf(32'h9000, 5);
        serve();
        check("busy_conf_idle", 256'(bus.ifc_idle), 256'(1));
        repeat (5) tick();
        check("busy_conf_no_req", 256'(bus.rd_req), 256'(0));
        pop();
        check("busy_conf_single", 256'(bus.inst_empty), 256'(1));

        expect_fetch(32'h4000, 20, 1'b1);
        conf(32'h4000, 20);
        repeat (16) serve();
        repeat (5) tick();
        check("full_no_req", 256'(bus.rd_req), 256'(0));
        check("full_busy", 256'(bus.ifc_idle), 256'(0));
        pop();
        tick();
        check("req_after_pop", 256'(bus.rd_req), 256'(1));
        serve();
        repeat (3) tick();
        check("full_again_no_req", 256'(bus.rd_req), 256'(0));
        repeat (3) begin
            pop();
            serve();
        end
        check("idle_after_twenty", 256'(bus.ifc_idle), 256'(1));
        repeat (16) pop();
        check("empty_after_twenty", 256'(bus.inst_empty), 256'(1));

        expect_fetch(32'h6000, 2, 1'b1);
        conf(32'h6000, 2);
        serve();
        serve(1'b1);
        check("swap_nonempty", 256'(bus.inst_empty), 256'(0));
        check("swap_head", 256'(bus.instruct), 256'(word_of(32'h6020)));
        pop();
        check("swap_count_one", 256'(bus.inst_empty), 256'(1));

        expect_fetch(32'h7000, 2, 1'b0);
        conf(32'h7000, 2);
        serve();
        check("pre_abort_nonempty", 256'(bus.inst_empty), 256'(0));
        serve(1'b0, 2);
        check("post_abort_idle", 256'(bus.ifc_idle), 256'(1));
        check("post_abort_empty", 256'(bus.inst_empty), 256'(1));
        expect_fetch(32'h8000, 1, 1'b1);
        conf(32'h8000, 1);
        serve();
        pop();

        expect_fetch(32'hFFFF_FFE0, 2, 1'b1);
        conf(32'hFFFF_FFE0, 2);
        repeat (2) serve();
        repeat (2) pop();
        check("wrap_empty", 256'(bus.inst_empty), 256'(1));

        repeat (3) tick();
        check("addr_queue_drained", 256'(exp_addr.size()), 256'(0));
        check("inst_queue_drained", 256'(exp_inst.size()), 256'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage feeding the compute/load controller. On a configuration pulse it reads a block of fixed-size instructions from DDR, one burst per instruction. It assembles each burst into an INST_LEN-bit word and queues it in an internal first-word-fall-through buffer. The controller reads that buffer through `instruct` / `inst_empty` / `inst_req`.

## Interface
- INST_LEN, 220, instruction width in bits
- DDR_ADDR_LEN, 32, DDR byte-address width
- DDR_DATA_LEN, 64, DDR read-data beat width
- SINGLE_LEN, 24, instruction-count width
- DEPTH_LOG, 4, log2 of buffer depth (16 entries)
- Derived: BEATS = ceil(INST_LEN/DDR_DATA_LEN) (4); INST_BYTES = BEATS*DDR_DATA_LEN/8 (32)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ifc_conf  in  1  one-cycle start pulse
- ifc_ddr_st_addr  in  DDR_ADDR_LEN  byte address of first instruction
- ifc_inst_num  in  SINGLE_LEN  number of instructions to fetch
- ifc_idle  out  1  high when no fetch is in progress
- rd_req  out  1  DDR burst request
- rd_addr  out  DDR_ADDR_LEN  burst byte address
- rd_beats  out  8  burst length; constant BEATS
- rd_ack  in  1  request accepted this cycle
- rd_valid  in  1  read beat valid
- rd_data  in  DDR_DATA_LEN  read beat
- instruct  out  INST_LEN  head-of-buffer instruction (FWFT)
- inst_empty  out  1  buffer empty
- inst_req  in  1  pop strobe from controller

## Operation
- FSM states: IDLE, REQ, RECV.
- IDLE:
  - ifc_conf with ifc_inst_num≠0 latches the address and count, then goes to REQ.
  - ifc_inst_num=0 is ignored; ifc_idle stays 1.
  - ifc_conf outside IDLE is ignored.
- REQ:
  - rd_req is asserted only when count<2^DEPTH_LOG; otherwise rd_req=0 and the FSM waits.
  - rd_req and rd_addr stay stable until rd_ack.
  - On the rd_req&&rd_ack edge the FSM goes to RECV and clears the beat counter.
- RECV:
  - Each rd_valid writes rd_data into slice [beat*DDR_DATA_LEN +: DDR_DATA_LEN] of an assembly register. Beat 0 is the LSBs.
  - Bits above INST_LEN are discarded.
  - On beat BEATS-1 the assembled word (including that beat) is pushed.
  - Then the address advances by INST_BYTES and the remaining count decrements.
  - Next state is REQ if the remaining count is nonzero, else IDLE.
- rd_valid outside RECV is ignored.
- One burst is outstanding at most. Because fullness is checked at REQ and pops only free space, the push never overflows.
- Buffer:
  - Circular, 2^DEPTH_LOG entries, rd/wr pointers wrap modulo depth, count has DEPTH_LOG+1 bits.
  - instruct = mem[rd_ptr], read combinationally.
  - inst_empty = (count==0).
- Pop on inst_req&&!inst_empty. inst_req while empty is ignored.
- Simultaneous push and pop leaves count unchanged.
- ifc_idle = (state==IDLE). A drained fetch does not require an empty buffer.
- Address arithmetic is modulo 2^DDR_ADDR_LEN.

## Timing
- Reset values: rd_req=0, rd_addr=0, ifc_idle=1, inst_empty=1, instruct=0 (memory contents don't-care; output forced 0 while empty), all pointers and counters 0, state IDLE.
- Asserting reset mid-burst aborts the burst and discards the buffer contents.
- ifc_conf at edge 0 → rd_req=1 and ifc_idle=0 from cycle 1.
- Last data beat at edge E → inst_empty=0 and valid instruct from cycle E+1.
- Next rd_req from cycle E+1, if space remains.
- Pop at edge P → the next entry appears on instruct from cycle P+1.
- The controller holds inst_req high for exactly one cycle per accepted instruction. The head must not change before that pop edge.
- Each instruction must be popped exactly once.

## Structure
- Shared package: INST_LEN, DDR_DATA_LEN, and derived BEATS/INST_BYTES, plus the FSM state encoding.
- One natural sub-module, `inst_fwft_fifo`: parameterised storage, pointers, count, empty/full.
- The FSM and assembly register live in `inst_fetch`.

## Test plan
- Conf addr=0x1000, num=3, memory model with ack after 2 cycles. Required response:
  - Three bursts at 0x1000, 0x1020, 0x1040.
  - Three instructs equal to the model words[219:0], in order.
  - ifc_idle returns to 1.
- num=20 with no pops:
  - Exactly 16 pushes, then rd_req stays 0.
  - One pop → one further burst.
  - Popping all → 20 instructions total, in order.
- Push and pop on the same edge at count=1: count stays 1 and the head becomes the new word.
- inst_req pulses while empty, ifc_conf while busy, num=0, and stray rd_valid in IDLE: none has any effect.
- Reset asserted during beat 2 of a burst: all outputs at reset values immediately. A new conf then fetches correctly.
- Start address 0xFFFF_FFE0 with num=2: the second burst address wraps to 0x0000_0000.
